// File: rtl/gecko_load_response_pkg.sv
// Shared gecko load-path types, the core-level queue depth and the load
// formatting / forwarding helpers used by the load-return stage.
package gecko_load_response_pkg;

    // Core-level default for the number of loads that may be in flight.
    localparam int GECKO_LOAD_QUEUE_DEPTH = 4;

    // RV32 load funct3 encodings.
    localparam logic [2:0] GECKO_FUNCT3_LB  = 3'b000;
    localparam logic [2:0] GECKO_FUNCT3_LH  = 3'b001;
    localparam logic [2:0] GECKO_FUNCT3_LW  = 3'b010;
    localparam logic [2:0] GECKO_FUNCT3_LBU = 3'b100;
    localparam logic [2:0] GECKO_FUNCT3_LHU = 3'b101;

    // Load descriptor pushed by execute alongside the memory request.
    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  reg_status;
        logic        jump_flag;
        logic [2:0]  op;
        logic [1:0]  offset;
    } gecko_mem_operation_t;

    // Result handed to writeback.
    typedef struct packed {
        logic [31:0] value;
        logic [31:0] addr;
        logic [4:0]  reg_status;
        logic        jump_flag;
        logic        speculative;
    } gecko_operation_t;

    // View of the writeback register that decode uses for bypassing.
    typedef struct packed {
        logic        valid;
        logic        speculative;
        logic [4:0]  reg_status;
        logic [31:0] value;
    } gecko_forwarded_t;

    // Extract and extend the addressed byte/halfword of an aligned word.
    function automatic gecko_operation_t gecko_get_load_operation(
        input gecko_mem_operation_t mem_op,
        input logic [31:0]          data
    );
        gecko_operation_t result;
        logic [7:0]       byte_sel;
        logic [15:0]      half_sel;

        case (mem_op.offset)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        half_sel = mem_op.offset[1] ? data[31:16] : data[15:0];

        result             = '0;
        result.addr        = mem_op.addr;
        result.reg_status  = mem_op.reg_status;
        result.jump_flag   = mem_op.jump_flag;
        result.speculative = 1'b0;
        case (mem_op.op)
            GECKO_FUNCT3_LB:  result.value = {{24{byte_sel[7]}}, byte_sel};
            GECKO_FUNCT3_LH:  result.value = {{16{half_sel[15]}}, half_sel};
            GECKO_FUNCT3_LBU: result.value = {24'h0, byte_sel};
            GECKO_FUNCT3_LHU: result.value = {16'h0, half_sel};
            default:          result.value = data;  // LW and anything unrecognised
        endcase
        return result;
    endfunction

    function automatic gecko_forwarded_t gecko_construct_forward(
        input logic             valid,
        input gecko_operation_t op
    );
        gecko_forwarded_t fwd;
        fwd.valid       = valid;
        fwd.speculative = op.speculative;
        fwd.reg_status  = op.reg_status;
        fwd.value       = op.value;
        return fwd;
    endfunction

endpackage

// File: rtl/gecko_load_response_if.sv
// Bundle of the descriptor, memory-response and writeback channels of the
// load-return stage. "slave" is the stage itself, "master" its surroundings.
interface gecko_load_response_if
    import gecko_load_response_pkg::*;
#(
    parameter int DEPTH = GECKO_LOAD_QUEUE_DEPTH
);
    logic                         op_valid;
    logic                         op_ready;
    gecko_mem_operation_t         op_data;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [31:0]                  resp_data;
    logic                         wb_valid;
    logic                         wb_ready;
    gecko_operation_t             wb_data;
    gecko_forwarded_t             forward;
    logic [$clog2(DEPTH+1)-1:0]   pending_count;
    logic                         resp_error;

    modport slave (
        input  op_valid, op_data, resp_valid, resp_data, wb_ready,
        output op_ready, resp_ready, wb_valid, wb_data, forward,
               pending_count, resp_error
    );

    modport master (
        output op_valid, op_data, resp_valid, resp_data, wb_ready,
        input  op_ready, resp_ready, wb_valid, wb_data, forward,
               pending_count, resp_error
    );
endinterface

// File: rtl/gecko_load_queue.sv
// Generic DEPTH-entry circular FIFO with a registered occupancy count.
// Push readiness depends only on the registered count, so a pop in the
// same cycle never frees room for a push while full.
module gecko_load_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_fire;
    logic             pop_fire;

    assign push_ready = (count_reg != FULL_COUNT);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop && (count_reg != '0);
    assign head_data  = mem_reg[rd_ptr_reg];
    assign count      = count_reg;

    // Descriptor storage: written at the tail, no reset needed.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks push minus pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/gecko_load_response.sv
// Load-return stage: queues load descriptors from execute, pairs each with
// its in-order memory response, formats the word and registers the result
// for writeback, with a forwarding view for decode.
module gecko_load_response
    import gecko_load_response_pkg::*;
#(
    parameter int DEPTH = GECKO_LOAD_QUEUE_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    gecko_load_response_if.slave bus
);
    localparam int CW = $clog2(DEPTH+1);

    gecko_mem_operation_t head_op;
    logic [CW-1:0]        count;
    logic                 queue_push_ready;
    logic                 resp_ready;
    logic                 resp_fire;
    logic                 wb_valid_reg;
    gecko_operation_t     wb_data_reg;
    logic                 resp_error_reg;

    gecko_load_queue #(
        .WIDTH ($bits(gecko_mem_operation_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_valid (bus.op_valid),
        .push_ready (queue_push_ready),
        .push_data  (bus.op_data),
        .pop        (resp_fire),
        .head_data  (head_op),
        .count      (count)
    );

    // A response is taken only when a descriptor waits for it and the
    // output register is free or draining this cycle.
    always_comb begin
        resp_ready = (count != '0) && (!wb_valid_reg || bus.wb_ready);
        resp_fire  = bus.resp_valid && resp_ready;
    end

    // Output register: load on a paired response, clear once drained,
    // otherwise hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_reg <= 1'b0;
            wb_data_reg  <= '0;
        end else if (resp_fire) begin
            wb_valid_reg <= 1'b1;
            wb_data_reg  <= gecko_get_load_operation(head_op, bus.resp_data);
        end else if (bus.wb_ready) begin
            wb_valid_reg <= 1'b0;
        end
    end

    // Sticky flag for a response that has no descriptor to pair with.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_error_reg <= 1'b0;
        end else if (bus.resp_valid && (count == '0)) begin
            resp_error_reg <= 1'b1;
        end
    end

    assign bus.op_ready      = queue_push_ready;
    assign bus.resp_ready    = resp_ready;
    assign bus.wb_valid      = wb_valid_reg;
    assign bus.wb_data       = wb_data_reg;
    assign bus.forward       = gecko_construct_forward(wb_valid_reg, wb_data_reg);
    assign bus.pending_count = count;
    assign bus.resp_error    = resp_error_reg;
endmodule

// File: tb/tb_gecko_load_response.sv
// Directed bench for the load-return stage (DEPTH = 4).
module tb_gecko_load_response;
    import gecko_load_response_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gecko_load_response_if #(.DEPTH(4)) bus ();

    gecko_load_response #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [4:0] r, input logic j,
                          input logic [2:0] f, input logic [1:0] o);
        gecko_mem_operation_t m;
        m.addr       = a;
        m.reg_status = r;
        m.jump_flag  = j;
        m.op         = f;
        m.offset     = o;
        bus.op_data  = m;
    endtask

    task automatic push(input logic [31:0] a, input logic [4:0] r, input logic j,
                        input logic [2:0] f, input logic [1:0] o);
        set_op(a, r, j, f, o);
        bus.op_valid = 1'b1;
        tick();
        bus.op_valid = 1'b0;
        $display("push addr=%08h op=%0d off=%0d pending=%0d", a, f, o, bus.pending_count);
    endtask

    task automatic resp(input logic [31:0] d);
        bus.resp_valid = 1'b1;
        bus.resp_data  = d;
        tick();
        bus.resp_valid = 1'b0;
        $display("resp data=%08h wb_valid=%0b value=%08h", d, bus.wb_valid, bus.wb_data.value);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst            = 1'b1;
        bus.op_valid   = 1'b0;
        bus.op_data    = '0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.wb_ready   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_wb_valid",   bus.wb_valid, 1'b0);
        chk("rst_pending",    bus.pending_count, 3'd0);
        chk("rst_resp_error", bus.resp_error, 1'b0);
        chk("rst_op_ready",   bus.op_ready, 1'b1);
        chk("rst_resp_ready", bus.resp_ready, 1'b0);
        chk("rst_fwd_valid",  bus.forward.valid, 1'b0);

        // Sign-extending byte, offset 3
        push(32'h0000_1003, 5'd5, 1'b1, GECKO_FUNCT3_LB, 2'd3);
        chk("lb_pending", bus.pending_count, 3'd1);
        chk("lb_resp_ready", bus.resp_ready, 1'b1);
        resp(32'h80FF_FF12);
        chk("lb_wb_valid",  bus.wb_valid, 1'b1);
        chk("lb_value",     bus.wb_data.value, 32'hFFFF_FF80);
        chk("lb_addr",      bus.wb_data.addr, 32'h0000_1003);
        chk("lb_reg",       bus.wb_data.reg_status, 5'd5);
        chk("lb_jump",      bus.wb_data.jump_flag, 1'b1);
        chk("lb_spec",      bus.wb_data.speculative, 1'b0);
        chk("lb_pending0",  bus.pending_count, 3'd0);
        chk("lb_fwd_valid", bus.forward.valid, 1'b1);
        chk("lb_fwd_value", bus.forward.value, 32'hFFFF_FF80);
        chk("lb_fwd_reg",   bus.forward.reg_status, 5'd5);

        // Zero-extending halfword, offset 2
        push(32'h0000_2002, 5'd7, 1'b0, GECKO_FUNCT3_LHU, 2'd2);
        resp(32'hBEEF_1234);
        chk("lhu_wb_valid", bus.wb_valid, 1'b1);
        chk("lhu_value",    bus.wb_data.value, 32'h0000_BEEF);
        chk("lhu_reg",      bus.wb_data.reg_status, 5'd7);
        tick();
        chk("lhu_drop",     bus.wb_valid, 1'b0);

        // Signed halfword, low half with negative sign
        push(32'h0000_3000, 5'd9, 1'b0, GECKO_FUNCT3_LH, 2'd0);
        resp(32'h1234_8001);
        chk("lh_value", bus.wb_data.value, 32'hFFFF_8001);
        // Unsigned byte, offset 1
        push(32'h0000_3001, 5'd10, 1'b0, GECKO_FUNCT3_LBU, 2'd1);
        resp(32'h1234_F501);
        chk("lbu_value", bus.wb_data.value, 32'h0000_00F5);
        // Unknown funct3 behaves as LW
        push(32'h0000_3004, 5'd11, 1'b0, 3'b111, 2'd2);
        resp(32'hCAFE_F00D);
        chk("other_value", bus.wb_data.value, 32'hCAFE_F00D);
        tick();

        // Full queue: no push in the cycle a pop happens while full
        for (int i = 0; i < 4; i++) begin
            push(32'h0000_4000 + 32'(i * 4), 5'(i + 1), 1'b0, GECKO_FUNCT3_LW, 2'd0);
        end
        chk("full_pending",  bus.pending_count, 3'd4);
        chk("full_op_ready", bus.op_ready, 1'b0);
        set_op(32'h0000_4FFF, 5'd31, 1'b0, GECKO_FUNCT3_LW, 2'd0);
        bus.op_valid   = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0033;
        #1;
        chk("full_resp_ready", bus.resp_ready, 1'b1);
        tick();
        bus.op_valid   = 1'b0;
        bus.resp_valid = 1'b0;
        #1;
        chk("full_pending3", bus.pending_count, 3'd3);
        chk("full_op_ready1", bus.op_ready, 1'b1);
        chk("full_value", bus.wb_data.value, 32'h0000_0033);
        chk("full_reg",   bus.wb_data.reg_status, 5'd1);
        resp(32'h0000_0044);
        chk("full_reg2",  bus.wb_data.reg_status, 5'd2);
        resp(32'h0000_0055);
        chk("full_addr3", bus.wb_data.addr, 32'h0000_4008);
        resp(32'h0000_0066);
        chk("full_reg4",  bus.wb_data.reg_status, 5'd4);
        chk("full_value4", bus.wb_data.value, 32'h0000_0066);
        chk("full_drained", bus.pending_count, 3'd0);
        tick();

        // Backpressure on writeback
        push(32'h0000_5000, 5'd12, 1'b0, GECKO_FUNCT3_LW, 2'd0);
        push(32'h0000_5004, 5'd13, 1'b0, GECKO_FUNCT3_LW, 2'd0);
        bus.wb_ready   = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0011;
        #1;
        chk("bp_resp_ready1", bus.resp_ready, 1'b1);
        tick();
        chk("bp_value1", bus.wb_data.value, 32'h0000_0011);
        chk("bp_pending1", bus.pending_count, 3'd1);
        bus.resp_data = 32'h0000_0022;
        #1;
        chk("bp_resp_ready0", bus.resp_ready, 1'b0);
        tick();
        chk("bp_hold_valid", bus.wb_valid, 1'b1);
        chk("bp_hold_value", bus.wb_data.value, 32'h0000_0011);
        chk("bp_hold_pending", bus.pending_count, 3'd1);
        bus.wb_ready = 1'b1;
        #1;
        chk("bp_resp_ready2", bus.resp_ready, 1'b1);
        tick();
        bus.resp_valid = 1'b0;
        $display("bp second result value=%08h", bus.wb_data.value);
        chk("bp_value2", bus.wb_data.value, 32'h0000_0022);
        chk("bp_reg2",   bus.wb_data.reg_status, 5'd13);
        chk("bp_pending0", bus.pending_count, 3'd0);
        tick();
        chk("bp_drop", bus.wb_valid, 1'b0);

        // Wrap-around: ten sequential LW pairs
        for (int i = 0; i < 10; i++) begin
            push(32'h0000_6000 + 32'(i * 4), 5'(i), 1'b0, GECKO_FUNCT3_LW, 2'd0);
            resp(32'hA000_0000 + 32'(i));
            chk("wrap_value", bus.wb_data.value, 32'hA000_0000 + 32'(i));
            chk("wrap_addr",  bus.wb_data.addr, 32'h0000_6000 + 32'(i * 4));
        end
        chk("wrap_pending", bus.pending_count, 3'd0);
        tick();

        // Unexpected response with an empty queue
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_DEAD;
        #1;
        chk("err_resp_ready", bus.resp_ready, 1'b0);
        tick();
        bus.resp_valid = 1'b0;
        chk("err_flag",    bus.resp_error, 1'b1);
        chk("err_pending", bus.pending_count, 3'd0);
        chk("err_wb_valid", bus.wb_valid, 1'b0);
        tick();
        chk("err_sticky",  bus.resp_error, 1'b1);

        // Reset mid-traffic with three loads pending
        for (int i = 0; i < 4; i++) begin
            push(32'h0000_7000 + 32'(i * 4), 5'(i + 20), 1'b0, GECKO_FUNCT3_LW, 2'd0);
        end
        resp(32'h1357_9BDF);
        chk("mid_pending", bus.pending_count, 3'd3);
        chk("mid_value",   bus.wb_data.value, 32'h1357_9BDF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        $display("reset wb_valid=%0b pending=%0d resp_error=%0b", bus.wb_valid, bus.pending_count, bus.resp_error);
        chk("rst2_wb_valid",   bus.wb_valid, 1'b0);
        chk("rst2_wb_value",   bus.wb_data.value, 32'h0);
        chk("rst2_wb_addr",    bus.wb_data.addr, 32'h0);
        chk("rst2_pending",    bus.pending_count, 3'd0);
        chk("rst2_resp_error", bus.resp_error, 1'b0);
        chk("rst2_op_ready",   bus.op_ready, 1'b1);
        chk("rst2_fwd_valid",  bus.forward.valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gecko_load_response.md
Name: gecko_load_response

Overview:
- Load-return stage of the gecko core, directly downstream of execute.
- Execute issues a load to data memory and, in the same cycle, pushes the matching gecko_mem_operation_t here.
- This block queues in-flight load descriptors and pairs each with its in-order memory response.
- It formats the read word with gecko_get_load_operation and presents a registered gecko_operation_t to writeback, plus a forwarding copy for decode.

Parameters:
- DEPTH, 4, max in-flight loads; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- op_valid  in  1  load descriptor valid
- op_ready  out  1  descriptor accepted when op_valid && op_ready
- op_data  in  $bits(gecko_mem_operation_t)  addr, reg_status, jump_flag, funct3 op, byte offset
- resp_valid  in  1  memory read data valid
- resp_ready  out  1  read data consumed when resp_valid && resp_ready
- resp_data  in  32  raw aligned memory word
- wb_valid  out  1  writeback result valid
- wb_ready  in  1  writeback accepts
- wb_data  out  $bits(gecko_operation_t)  formatted load result
- forward  out  $bits(gecko_forwarded_t)  forwarding view of wb register
- pending_count  out  $clog2(DEPTH+1)  descriptors queued, not yet paired
- resp_error  out  1  sticky: response arrived with empty queue

Behaviour:
- Reset (rst high at clk edge): read/write pointers 0, pending_count 0, wb_valid 0, wb_data 0, resp_error 0. Everything in flight is discarded; memory side must also be reset.
- Descriptor queue is a circular buffer of DEPTH gecko_mem_operation_t. Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- op_ready = (pending_count != DEPTH), computed from registered count only.
  - There is no same-cycle bypass: when full, a simultaneous pop does not allow a push that cycle.
- Responses return strictly in order and pair with the queue head.
- resp_ready = (pending_count != 0) && (!wb_valid || wb_ready).
- Response handshake:
  - next cycle wb_valid = 1;
  - wb_data = gecko_get_load_operation(head, resp_data), with speculative = 0;
  - head is popped.
  - Latency is response-to-wb_valid = 1 cycle.
- Output register holding:
  - If wb_valid && wb_ready and no response is accepted: wb_valid clears next cycle.
  - If wb_valid && !wb_ready: wb_data and wb_valid hold stable.
- Push and pop in the same cycle: count is unchanged, both pointers advance.
- Count update: pending_count += push - pop; it never exceeds DEPTH and never underflows.
- Unexpected response: resp_valid while pending_count == 0 sets resp_error = 1 (sticky until rst). The data is not consumed (resp_ready = 0) and state is otherwise unchanged.
- forward = gecko_construct_forward(wb_valid, wb_data); purely combinational from the registered output.
- Load formatting:
  - LB/LH sign-extend, LBU/LHU zero-extend.
  - Byte select uses offset; halfword select uses offset[1].
  - LW passes resp_data through; any other funct3 is treated as LW.
- No combinational path from resp_valid or op_valid to op_ready. The only comb path into resp_ready is wb_ready.

Decomposition:
- gecko package already holds gecko_mem_operation_t, gecko_operation_t, gecko_forwarded_t, gecko_get_load_operation and gecko_construct_forward. No new typedefs.
- Add to package: localparam GECKO_LOAD_QUEUE_DEPTH = 4 as the core-level default.
- One natural sub-module: gecko_load_queue, a generic DEPTH-entry synchronous FIFO with registered count and no bypass, parameterised on width. The top holds the output register, pairing logic and error flag.

Test Plan:
- Sign-extending byte: push LB, offset 3; resp_data 0x80FF_FF12 → one cycle later wb_valid = 1, value 0xFFFF_FF80, addr/reg_status/jump_flag echoed, speculative 0.
- Zero-extending half: push LHU, offset 2; resp_data 0xBEEF_1234 → value 0x0000_BEEF. With wb_ready = 1, wb_valid drops the following cycle.
- Full queue, DEPTH = 4: push 4 descriptors with no responses → pending_count = 4 and op_ready = 0. One response plus simultaneous op_valid → no push that cycle, count 3. Next cycle op_ready = 1.
- Backpressure: 2 queued loads, wb_ready = 0, responses 0x11 then 0x22 presented back-to-back → first accepted; resp_ready = 0 while wb holds 0x11. After wb_ready = 1, 0x22 is accepted and appears one cycle later, in order.
- Wrap-around: 10 sequential LW push/response pairs with DEPTH = 4 → 10 wb results in order, values equal to resp_data, pending_count returns to 0.
- Error and reset: resp_valid with an empty queue → resp_error = 1, resp_ready = 0. Then rst mid-traffic with 3 pending → all outputs zero next cycle and resp_error cleared.
